ring_switch_allocator: RTL
==========================

Name: ring_switch_allocator

Overview:
- Per-output switch allocator for the ring router. Inputs are West (0), East (1) and Local (2); each input presents one flit per cycle with a one-hot output request taken from the lookahead route decoded upstream.
- For each output: round-robin arbitration among head flits, wormhole locking until the tail flit passes, and credit-based flow control toward the downstream buffer.
- Drives the crossbar select and the input-buffer pop signals.

Parameters:
- NumPorts, 3: number of input and output ports. Index 0=West, 1=East, 2=Local.
- BufDepth, 4: downstream buffer depth per output, equal to the initial credit count. Must be ≥1.
- CntW, $clog2(BufDepth+1): credit counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_valid  in  NumPorts  flit present at input i
- in_head  in  NumPorts  flit at input i is a head
- in_tail  in  NumPorts  flit at input i is a tail (head and tail together = single-flit packet)
- in_req  in  NumPorts*NumPorts  slice [i*N +: N] is the one-hot output requested by input i
- in_ready  out  NumPorts  input i flit is transferred this cycle (pop)
- xbar_sel  out  NumPorts*NumPorts  slice [o*N +: N] is the one-hot input driving output o, all-zero when idle
- out_valid  out  NumPorts  output o carries a flit this cycle
- credit_in  in  NumPorts  one-cycle pulse: downstream freed one slot on output o
- credit_err  out  1  sticky flag: credit overflow or illegal U-turn request seen

Behaviour:
- Reset (rst=0 at posedge):
  - all outputs unlocked; rr_ptr[o]=0; credits[o]=BufDepth; credit_err=0.
  - in_ready, xbar_sel and out_valid are combinational from state and are 0 while state is reset.
- Transfer: xfer[i] = in_valid[i] & in_ready[i]. At most one transfer per input and one per output per cycle.
- A request from input i is legal only if in_valid[i]=1, in_req slice i is exactly one-hot, and the requested output o≠i for i∈{0,1}. Local→Local is allowed.
  - Zero-hot or multi-hot request: never granted, no error.
  - U-turn request (o=i, i≠2): never granted; sets credit_err.
- Output o, unlocked:
  - Candidates are legal requests for o with in_head=1.
  - Eligible only if credits[o]>0.
  - Winner is the first candidate scanning from rr_ptr[o] upward, modulo NumPorts.
  - Winner gets in_ready=1, xbar_sel[o] is one-hot to the winner, and out_valid[o]=1, all in the same cycle.
  - On a winner transfer: rr_ptr[o] ← (winner+1) mod NumPorts. If in_tail=0, lock o to the winner from the next cycle.
- Output o, locked to owner k:
  - Only input k may transfer, and only if it has a legal request for o, in_head=0, and credits[o]>0.
  - Other inputs stall, including head flits.
  - A transfer with in_tail=1 unlocks o from the next cycle. The lock is held across idle cycles with no timeout.
  - A head flit from k while o is locked to k: stalled (protocol violation), no state change.
- Non-head flit to an unlocked output, or to an output locked to another input: stalled indefinitely.
- Credits (per output, registered):
  - A transfer alone decrements. A credit_in pulse alone increments. Both in the same cycle: no change.
  - credit_in while credits=BufDepth and no transfer: counter holds and credit_err sets.
  - credits=0: no grant. A credit arriving that cycle is usable from the next cycle (no bypass).
- Latency: grant is combinational (0 cycles); lock, pointer and credit updates take effect at the next posedge.
- Reset mid-packet: locks are dropped and credits restored. Upstream and downstream are reset together.

Test Plan:
- After reset, Local requests East with a single-flit packet (head=tail=1): in_ready[2]=1 and xbar_sel[East]=3'b100 in the same cycle. Next cycle credits[East]=3 and rr_ptr[East]=0.
- West and Local both send heads to East every cycle (rr_ptr=0): grant order West, Local, West, … on successive single-flit packets.
- Local sends a 4-flit packet to East (head, body, body, tail) while West presents a head to East: West stalls 4 cycles and is granted on cycle 5. The lock releases exactly after the tail.
- BufDepth=4, no credit_in, Local streams 6 single-flit packets East: 4 transfers, then in_ready=0. One credit_in pulse gives exactly 1 more transfer, starting the cycle after the pulse.
- Simultaneous transfer and credit_in on West with credits=2: stays 2. credit_in at credits=4 with no transfer: stays 4 and credit_err=1.
- East input requests East (U-turn): never ready and credit_err=1. Assert rst=0 mid-packet while West is locked: next cycle unlocked, credits=4, and credit_err=0 until the next violation.

Source files
------------

// File: rtl/ring_switch_allocator.sv
// Per-output switch allocator: round-robin on head flits, wormhole lock until tail, credit flow control per output.
// Latency: grant, crossbar select and input pop are combinational; lock, pointer and credit state update on the next clk edge.
// Backpressure: an input is popped only when it owns or wins its output and that output holds a credit; otherwise it stalls in place.
module ring_switch_allocator #(
    parameter int NumPorts = 3,
    parameter int BufDepth = 4,
    parameter int CntW     = $clog2(BufDepth + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumPorts-1:0]          in_valid,
    input  logic [NumPorts-1:0]          in_head,
    input  logic [NumPorts-1:0]          in_tail,
    input  logic [NumPorts*NumPorts-1:0] in_req,
    output logic [NumPorts-1:0]          in_ready,
    output logic [NumPorts*NumPorts-1:0] xbar_sel,
    output logic [NumPorts-1:0]          out_valid,
    input  logic [NumPorts-1:0]          credit_in,
    output logic                         credit_err
);

    localparam int              PtrW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int              LocalPort = NumPorts - 1;
    localparam logic [CntW-1:0] CredFull  = CntW'(BufDepth);
    localparam logic [PtrW-1:0] LastPort  = PtrW'(NumPorts - 1);

    // Decoded request per input and its classification
    logic [NumPorts-1:0] req    [NumPorts];
    logic [NumPorts-1:0] legal;
    logic [NumPorts-1:0] uturn;

    // Per-output grant vector (one-hot over inputs) and the granted input index
    logic [NumPorts-1:0] grant  [NumPorts];
    logic [PtrW-1:0]     winner [NumPorts];
    logic [NumPorts-1:0] ovf;

    // Architectural state
    logic [NumPorts-1:0] locked;
    logic [PtrW-1:0]     owner   [NumPorts];
    logic [PtrW-1:0]     rr_ptr  [NumPorts];
    logic [CntW-1:0]     credits [NumPorts];

    // Input index reached by stepping 'off' places past 'base', wrapping at NumPorts.
    function automatic logic [PtrW-1:0] step_idx(logic [PtrW-1:0] base, int off);
        int s;
        s = int'(base) + off;
        if (s >= NumPorts) s = s - NumPorts;
        return PtrW'(s);
    endfunction

    // Classify each input: a one-hot request is legal unless a ring input asks to turn straight back.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            req[i]   = in_req[i*NumPorts +: NumPorts];
            legal[i] = 1'b0;
            uturn[i] = 1'b0;
            if (in_valid[i] && $onehot(req[i])) begin
                if (i != LocalPort && req[i][i]) uturn[i] = 1'b1;
                else                             legal[i] = 1'b1;
            end
        end
    end

    // Per output: follow the lock owner's body flits, or pick the first head from rr_ptr; no credit, no grant.
    always_comb begin
        for (int o = 0; o < NumPorts; o++) begin
            logic [PtrW-1:0] idx;
            idx       = '0;
            grant[o]  = '0;
            winner[o] = '0;
            if (credits[o] != '0) begin
                if (locked[o]) begin
                    if (legal[owner[o]] && req[owner[o]][o] && !in_head[owner[o]]) begin
                        grant[o][owner[o]] = 1'b1;
                        winner[o]          = owner[o];
                    end
                end else begin
                    // Scan farthest-first so the last hit is the closest one to the pointer.
                    for (int off = NumPorts - 1; off >= 0; off--) begin
                        idx = step_idx(rr_ptr[o], off);
                        if (legal[idx] && req[idx][o] && in_head[idx]) begin
                            grant[o]      = '0;
                            grant[o][idx] = 1'b1;
                            winner[o]     = idx;
                        end
                    end
                end
            end
        end
    end

    // Fold grants into crossbar selects, output valids, input pops and credit-overflow detection.
    always_comb begin
        in_ready  = '0;
        xbar_sel  = '0;
        out_valid = '0;
        ovf       = '0;
        for (int o = 0; o < NumPorts; o++) begin
            xbar_sel[o*NumPorts +: NumPorts] = grant[o];
            out_valid[o] = |grant[o];
            in_ready     = in_ready | grant[o];
            ovf[o]       = credit_in[o] && !(|grant[o]) && (credits[o] == CredFull);
        end
    end

    // Lock ownership, round-robin pointers, credit counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            locked     <= '0;
            credit_err <= 1'b0;
            for (int o = 0; o < NumPorts; o++) begin
                owner[o]   <= '0;
                rr_ptr[o]  <= '0;
                credits[o] <= CredFull;
            end
        end else begin
            for (int o = 0; o < NumPorts; o++) begin
                if (out_valid[o]) begin
                    if (!locked[o]) begin
                        rr_ptr[o] <= (winner[o] == LastPort) ? '0 : winner[o] + 1'b1;
                        if (!in_tail[winner[o]]) begin
                            locked[o] <= 1'b1;
                            owner[o]  <= winner[o];
                        end
                    end else if (in_tail[owner[o]]) begin
                        locked[o] <= 1'b0;
                    end
                end
                // A grant and a returned credit in the same cycle cancel out.
                if (out_valid[o] && !credit_in[o]) begin
                    credits[o] <= credits[o] - 1'b1;
                end else if (!out_valid[o] && credit_in[o] && credits[o] != CredFull) begin
                    credits[o] <= credits[o] + 1'b1;
                end
            end
            credit_err <= credit_err | (|uturn) | (|ovf);
        end
    end

endmodule
